// File: rtl/score_display_ctrl.sv
// Score display sequencer: owns the current and high score, picks the value
// sent to the 7-seg decoder and runs the game-over blink/alternate sequence.
module score_display_ctrl #(
  parameter int unsigned MAX_SCORE   = 64,
  parameter int unsigned TICK_DIV    = 25000000,
  parameter int unsigned BLINK_TICKS = 6,
  parameter int unsigned ALT_TICKS   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_start,
  input  logic       round_won,
  input  logic       game_over,
  output logic [6:0] score_x,
  output logic       blank,
  output logic       show_hi,
  output logic       new_record,
  output logic [6:0] score,
  output logic [6:0] hi_score,
  output logic [1:0] state
);

  localparam int unsigned SW   = 7;
  localparam int unsigned CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned IMAX = (BLINK_TICKS > ALT_TICKS) ? BLINK_TICKS : ALT_TICKS;
  localparam int unsigned IW   = $clog2(IMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_BLINK = 2'd2,
    S_SHOW  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   score_q, score_d;
  logic [SW-1:0]   hi_q, hi_d;
  logic            rec_q, rec_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   idx_inc;
  logic            alt_q, alt_d;
  logic            blank_q, blank_d;
  logic            show_hi_q, show_hi_d;
  logic [SW-1:0]   score_x_q, score_x_d;
  logic            in_over;
  logic            tick;
  logic            entering;

  assign in_over = (state_q == S_BLINK) || (state_q == S_SHOW);
  assign tick    = in_over && (cnt_q == CW'(TICK_DIV - 1));
  assign idx_inc = idx_q + IW'(1);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      score_q   <= '0;
      hi_q      <= '0;
      rec_q     <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= '0;
      alt_q     <= 1'b0;
      blank_q   <= 1'b0;
      show_hi_q <= 1'b1;
      score_x_q <= '0;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      hi_q      <= hi_d;
      rec_q     <= rec_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      alt_q     <= alt_d;
      blank_q   <= blank_d;
      show_hi_q <= show_hi_d;
      score_x_q <= score_x_d;
    end
  end

  // Next state and score bookkeeping; game_start > game_over > round_won
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    hi_d    = hi_q;
    rec_d   = rec_q;
    unique case (state_q)
      S_IDLE: begin
        if (game_start) begin
          state_d = S_PLAY;
          score_d = '0;
          rec_d   = 1'b0;
        end
      end
      S_PLAY: begin
        if (game_start) begin
          score_d = '0;
        end else if (game_over) begin
          state_d = S_BLINK;
          if (score_q > hi_q) begin
            hi_d  = score_q;
            rec_d = 1'b1;
          end
        end else if (round_won && (score_q < SW'(MAX_SCORE))) begin
          score_d = score_q + SW'(1);
        end
      end
      S_BLINK: begin
        if (game_start) begin
          state_d = S_PLAY;
          score_d = '0;
          rec_d   = 1'b0;
        end else if (tick && (idx_inc == IW'(BLINK_TICKS))) begin
          state_d = S_SHOW;
        end
      end
      default: begin
        if (game_start) begin
          state_d = S_PLAY;
          score_d = '0;
          rec_d   = 1'b0;
        end
      end
    endcase
  end

  // Tick timer, blink/alternate phase and next registered display outputs
  always_comb begin
    entering = (state_d != state_q);
    cnt_d    = '0;
    idx_d    = '0;
    alt_d    = 1'b0;
    blank_d  = 1'b0;
    if (!entering && in_over) begin
      cnt_d   = tick ? '0 : cnt_q + CW'(1);
      idx_d   = idx_q;
      alt_d   = alt_q;
      blank_d = blank_q;
      if (tick) begin
        if (state_q == S_BLINK) begin
          idx_d   = idx_inc;
          blank_d = ~blank_q;
        end else if (idx_inc == IW'(ALT_TICKS)) begin
          idx_d = '0;
          alt_d = ~alt_q;
        end else begin
          idx_d = idx_inc;
        end
      end
    end
    show_hi_d = (state_d == S_IDLE) || ((state_d == S_SHOW) && alt_d);
    score_x_d = show_hi_d ? hi_d : score_d;
  end

  assign score_x    = score_x_q;
  assign blank      = blank_q;
  assign show_hi    = show_hi_q;
  assign new_record = rec_q;
  assign score      = score_q;
  assign hi_score   = hi_q;
  assign state      = state_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl with a short tick period so the
// blink and alternate sequences complete in a few dozen cycles.
module tb_score_display_ctrl;

  logic       clk;
  logic       rst_n;
  logic       game_start;
  logic       round_won;
  logic       game_over;
  logic [6:0] score_x;
  logic       blank;
  logic       show_hi;
  logic       new_record;
  logic [6:0] score;
  logic [6:0] hi_score;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic gs;
    logic rw;
    logic go;
    int   st;
    int   sc;
    int   hi;
    int   x;
    int   sh;
    int   bl;
    int   rec;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs [NVEC];

  score_display_ctrl #(
    .MAX_SCORE  (64),
    .TICK_DIV   (4),
    .BLINK_TICKS(6),
    .ALT_TICKS  (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .game_start(game_start),
    .round_won (round_won),
    .game_over (game_over),
    .score_x   (score_x),
    .blank     (blank),
    .show_hi   (show_hi),
    .new_record(new_record),
    .score     (score),
    .hi_score  (hi_score),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic gs, input logic rw, input logic go,
                              input int st, input int sc, input int hi, input int x,
                              input int sh, input int bl, input int rec);
    vec_t v;
    v.gs = gs; v.rw = rw; v.go = go;
    v.st = st; v.sc = sc; v.hi = hi; v.x = x; v.sh = sh; v.bl = bl; v.rec = rec;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int st, input int sc, input int hi,
                         input int x, input int sh, input int bl, input int rec);
    chk({name, ".state"},      int'(state),      st);
    chk({name, ".score"},      int'(score),      sc);
    chk({name, ".hi_score"},   int'(hi_score),   hi);
    chk({name, ".score_x"},    int'(score_x),    x);
    chk({name, ".show_hi"},    int'(show_hi),    sh);
    chk({name, ".blank"},      int'(blank),      bl);
    chk({name, ".new_record"}, int'(new_record), rec);
  endtask

  // Drive one cycle of pulses; returns 1 time unit after the sampling edge
  task automatic step(input logic gs, input logic rw, input logic go);
    game_start = gs;
    round_won  = rw;
    game_over  = go;
    @(posedge clk);
    #1;
    game_start = 1'b0;
    round_won  = 1'b0;
    game_over  = 1'b0;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      step(vecs[i].gs, vecs[i].rw, vecs[i].go);
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].sc, vecs[i].hi,
              vecs[i].x, vecs[i].sh, vecs[i].bl, vecs[i].rec);
    end
  endtask

  initial begin
    //                gs    rw    go   st sc  hi  x  sh bl rec
    vecs[0]  = mk(1'b0, 1'b0, 1'b0, 0, 0,  0, 0, 1, 0, 0);
    vecs[1]  = mk(1'b0, 1'b1, 1'b0, 0, 0,  0, 0, 1, 0, 0);
    vecs[2]  = mk(1'b0, 1'b0, 1'b1, 0, 0,  0, 0, 1, 0, 0);
    vecs[3]  = mk(1'b1, 1'b0, 1'b0, 1, 0,  0, 0, 0, 0, 0);
    vecs[4]  = mk(1'b0, 1'b1, 1'b0, 1, 1,  0, 1, 0, 0, 0);
    vecs[5]  = mk(1'b0, 1'b1, 1'b0, 1, 2,  0, 2, 0, 0, 0);
    vecs[6]  = mk(1'b0, 1'b1, 1'b0, 1, 3,  0, 3, 0, 0, 0);
    vecs[7]  = mk(1'b0, 1'b1, 1'b0, 1, 4,  0, 4, 0, 0, 0);
    vecs[8]  = mk(1'b0, 1'b1, 1'b0, 1, 5,  0, 5, 0, 0, 0);
    vecs[9]  = mk(1'b0, 1'b0, 1'b1, 2, 5,  5, 5, 0, 0, 1);
    vecs[10] = mk(1'b1, 1'b0, 1'b0, 1, 0,  5, 0, 0, 0, 0);
    vecs[11] = mk(1'b0, 1'b1, 1'b0, 1, 1,  5, 1, 0, 0, 0);
    vecs[12] = mk(1'b0, 1'b1, 1'b0, 1, 2,  5, 2, 0, 0, 0);
    vecs[13] = mk(1'b0, 1'b1, 1'b0, 1, 3,  5, 3, 0, 0, 0);
    vecs[14] = mk(1'b0, 1'b0, 1'b1, 2, 3,  5, 3, 0, 0, 0);
    vecs[15] = mk(1'b1, 1'b0, 1'b0, 1, 0, 64, 0, 0, 0, 0);
    vecs[16] = mk(1'b0, 1'b1, 1'b0, 1, 1, 64, 1, 0, 0, 0);
    vecs[17] = mk(1'b0, 1'b1, 1'b0, 1, 2, 64, 2, 0, 0, 0);
    vecs[18] = mk(1'b0, 1'b1, 1'b1, 2, 2, 64, 2, 0, 0, 0);
    vecs[19] = mk(1'b1, 1'b0, 1'b0, 1, 0, 64, 0, 0, 0, 0);
    vecs[20] = mk(1'b0, 1'b1, 1'b0, 1, 1, 64, 1, 0, 0, 0);
    vecs[21] = mk(1'b1, 1'b0, 1'b1, 1, 0, 64, 0, 0, 0, 0);
    vecs[22] = mk(1'b0, 1'b1, 1'b0, 1, 1, 64, 1, 0, 0, 0);
    vecs[23] = mk(1'b1, 1'b1, 1'b0, 1, 0, 64, 0, 0, 0, 0);
    vecs[24] = mk(1'b0, 1'b1, 1'b0, 1, 1, 64, 1, 0, 0, 0);
    vecs[25] = mk(1'b0, 1'b0, 1'b1, 2, 1, 64, 1, 0, 0, 0);

    rst_n      = 1'b0;
    game_start = 1'b0;
    round_won  = 1'b0;
    game_over  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle holds the high-score view
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("idle%0d.state", i), int'(state), 0);
      chk($sformatf("idle%0d.show_hi", i), int'(show_hi), 1);
    end

    // First game: 5 rounds, new record, then blink
    run_vecs(0, 9);
    for (int k = 1; k <= 24; k++) begin
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("blink%0d.state", k), int'(state), (k < 24) ? 2 : 3);
      chk($sformatf("blink%0d.blank", k), int'(blank), ((k / 4) % 2 == 1 && k < 24) ? 1 : 0);
    end
    chk_all("show_entry", 3, 5, 5, 5, 0, 0, 1);
    for (int j = 1; j <= 16; j++) begin
      step(1'b0, j == 3, j == 5);
      chk($sformatf("show%0d.show_hi", j), int'(show_hi), ((j / 8) % 2 == 1) ? 1 : 0);
      chk($sformatf("show%0d.score_x", j), int'(score_x), 5);
      chk($sformatf("show%0d.state", j), int'(state), 3);
    end

    // Second game: 3 rounds, no record, alternate 3 / 5
    run_vecs(10, 14);
    repeat (24) step(1'b0, 1'b0, 1'b0);
    chk_all("show2_entry", 3, 3, 5, 3, 0, 0, 0);
    for (int j = 1; j <= 24; j++) begin
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("alt%0d.score_x", j), int'(score_x), ((j / 8) % 2 == 1) ? 5 : 3);
      chk($sformatf("alt%0d.show_hi", j), int'(show_hi), ((j / 8) % 2 == 1) ? 1 : 0);
    end

    // Saturation at 64
    step(1'b1, 1'b0, 1'b0);
    chk_all("sat_start", 1, 0, 5, 0, 0, 0, 0);
    for (int i = 1; i <= 70; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk($sformatf("sat%0d.score", i), int'(score), (i > 64) ? 64 : i);
      chk($sformatf("sat%0d.score_x", i), int'(score_x), (i > 64) ? 64 : i);
    end
    step(1'b0, 1'b0, 1'b1);
    chk_all("sat_over", 2, 64, 64, 64, 0, 0, 1);

    // Restart while the display is dark mid-blink, then priority cases
    repeat (5) step(1'b0, 1'b0, 1'b0);
    chk("midblink.blank", int'(blank), 1);
    run_vecs(15, 25);

    // Asynchronous reset while blank is high
    repeat (4) step(1'b0, 1'b0, 1'b0);
    chk("prerst.blank", int'(blank), 1);
    chk("prerst.state", int'(state), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk_all("post_rst", 0, 0, 0, 0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
